io_interval_timer: RTL

- Memory-mapped interval timer peripheral on the 16-bit processor's data bus, downstream of the processor next to the LEDR and HEX I/O registers.
- The processor writes load and control values with ordinary store instructions. It polls count and status with load instructions.
- Provides programmable delays for lab programs without software busy-count loops. The timeout flag is also exported for direct display on an LED.

---
 rtl/io_interval_timer.sv | 109 ++++++++++
 1 files changed

// File: rtl/io_interval_timer.sv
// Memory-mapped interval timer: CTRL/LOAD/COUNT/STATUS in a 4K window, with a TO flag exported to an LED.
// Read data and rd_sel are registered, so there is one cycle of latency; the block always accepts writes and never stalls.
module io_interval_timer #(
    parameter logic [3:0] BASE     = 4'h3,
    parameter int         PRESCALE = 50000
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] ADDR,
    input  logic [15:0] DOUT,
    input  logic        W,
    output logic [15:0] DIN,
    output logic        rd_sel,
    output logic        timeout
);

    localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

    logic        run;
    logic        cont;
    logic        to;
    logic [15:0] load;
    logic [15:0] count;
    logic [15:0] pcount;
    logic [15:0] rd_mux;

    logic sel;
    logic ctrl_wr;
    logic load_wr;
    logic stat_clr;
    logic tick;
    logic expiry;
    logic unused_addr;

    // ADDR[11:2] are deliberately not decoded, so the registers alias across the window.
    assign unused_addr = ^ADDR[11:2];

    assign sel      = (ADDR[15:12] == BASE);
    assign ctrl_wr  = sel && W && (ADDR[1:0] == 2'd0);
    assign load_wr  = sel && W && (ADDR[1:0] == 2'd1);
    assign stat_clr = sel && W && (ADDR[1:0] == 2'd3) && DOUT[0];
    assign tick     = run && (pcount == PS_LAST);
    // A COUNT of 0 expires just like 1, which is why LOAD=0 behaves as LOAD=1.
    assign expiry   = tick && (count <= 16'd1);

    assign timeout = to;

    always_comb begin
        rd_mux = 16'd0;
        if (sel) begin
            case (ADDR[1:0])
                2'd0:    rd_mux = {14'd0, cont, run};
                2'd1:    rd_mux = load;
                2'd2:    rd_mux = count;
                default: rd_mux = {15'd0, to};
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            run    <= 1'b0;
            cont   <= 1'b0;
            to     <= 1'b0;
            load   <= 16'd0;
            count  <= 16'd0;
            pcount <= 16'd0;
            DIN    <= 16'd0;
            rd_sel <= 1'b0;
        end else begin
            if (!run || ctrl_wr || load_wr || tick)
                pcount <= 16'd0;
            else
                pcount <= pcount + 16'd1;

            if (load_wr)
                load <= DOUT;

            if (load_wr)
                count <= DOUT;
            else if (tick) begin
                if (count > 16'd1)
                    count <= count - 16'd1;
                else if (cont)
                    count <= load;
                else
                    count <= 16'd0;
            end

            // An explicit CTRL write outranks the one-shot RUN clear on the same edge.
            if (ctrl_wr) begin
                run  <= DOUT[0];
                cont <= DOUT[1];
            end else if (expiry && !cont) begin
                run <= 1'b0;
            end

            // Setting outranks a software clear on the same edge so no expiry is lost.
            if (expiry)
                to <= 1'b1;
            else if (stat_clr)
                to <= 1'b0;

            DIN    <= rd_mux;
            rd_sel <= sel && !W;
        end
    end

endmodule
